// File: rtl/sb_pkg.sv
// sb_pkg: shared types and constants for the store buffer.
//   sb_entry_t  - one buffered store {pc, word address, lane-aligned data, byte enables}
//   SB_LANES    - byte lanes per data word
//   SB_DEPTH    - default number of buffer entries
package sb_pkg;

  localparam int SB_DEPTH = 4;
  localparam int SB_LANES = 4;

  typedef struct packed {
    logic [31:0]         pc;
    logic [29:0]         waddr;
    logic [31:0]         data;
    logic [SB_LANES-1:0] be;
  } sb_entry_t;

endpackage

// File: rtl/sb_fwd_merge.sv
// sb_fwd_merge: combinational store-to-load forwarding.
// Every byte lane of the loaded word comes from the youngest valid buffered
// store that hits the same word address with that lane enabled. Lanes with
// no such store come from the data memory read data.
// Ports:
//   entries_i  - buffer entry array
//   valid_i    - per-entry valid mask
//   head_i     - index of the oldest entry (defines age order)
//   ld_waddr_i - load word address (byte address [31:2])
//   dm_rd_i    - data memory read data
//   ld_data_o  - merged load word
module sb_fwd_merge
  import sb_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH
) (
  input  sb_entry_t                  entries_i [DEPTH],
  input  logic [DEPTH-1:0]           valid_i,
  input  logic [$clog2(DEPTH)-1:0]   head_i,
  input  logic [29:0]                ld_waddr_i,
  input  logic [31:0]                dm_rd_i,
  output logic [31:0]                ld_data_o
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] idx;
  logic          unused_pc;

  // Walk oldest to youngest so later hits overwrite earlier ones.
  always_comb begin
    ld_data_o = dm_rd_i;
    idx       = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_i + PW'(k);
      if (valid_i[idx] && (entries_i[idx].waddr == ld_waddr_i)) begin
        for (int b = 0; b < SB_LANES; b++) begin
          if (entries_i[idx].be[b]) begin
            ld_data_o[8*b +: 8] = entries_i[idx].data[8*b +: 8];
          end
        end
      end
    end
  end

  always_comb begin
    unused_pc = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      unused_pc = unused_pc ^ (^entries_i[i].pc);
    end
  end

endmodule

// File: rtl/store_buffer.sv
// store_buffer: FIFO of committed stores in front of the data memory.
// Drains one store per cycle into the DM write port whenever no load needs
// the port, or unconditionally when full (a full buffer stalls the load so
// the pipeline cannot starve the drain). Loads read DM through this block
// with newer buffered bytes merged in.
// Ports:
//   clk, reset                       - clock, async active-low reset
//   st_valid/st_ready, st_pc,
//   st_addr, st_wdata, st_be         - store enqueue interface
//   ld_valid, ld_addr, ld_stall,
//   ld_data                          - load interface (combinational data)
//   dm_addr, dm_we, dm_wd, dm_be,
//   dm_pc, dm_rd                     - data memory port
//   sb_empty                         - no buffered stores
module store_buffer
  import sb_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [31:0] st_pc,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_wdata,
  input  logic [3:0]  st_be,
  input  logic        ld_valid,
  input  logic [31:0] ld_addr,
  output logic        ld_stall,
  output logic [31:0] ld_data,
  output logic [31:0] dm_addr,
  output logic        dm_we,
  output logic [31:0] dm_wd,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_pc,
  input  logic [31:0] dm_rd,
  output logic        sb_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  sb_entry_t        entries_q [DEPTH];
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;

  logic             full;
  logic             enq;
  logic             drain;
  sb_entry_t        head_e;
  logic [PW-1:0]    age [DEPTH];
  logic [DEPTH-1:0] valid;
  logic             unused_st_lsb;

  assign full     = (count_q == CW'(DEPTH));
  assign st_ready = !full;
  assign enq      = st_valid && st_ready;
  assign drain    = (count_q != '0) && (!ld_valid || full);
  assign sb_empty = (count_q == '0);
  assign ld_stall = ld_valid && full;
  assign head_e   = entries_q[head_q];

  assign unused_st_lsb = ^st_addr[1:0];

  // Entry i is live when its distance from head is below the occupancy.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      age[i]   = PW'(i) - head_q;
      valid[i] = ({1'b0, age[i]} < count_q);
    end
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (drain) head_d = head_q + PW'(1);
    if (enq)   tail_d = tail_q + PW'(1);
    count_d = count_q + CW'(enq) - CW'(drain);
  end

  always_comb begin
    dm_we   = drain;
    dm_addr = drain ? {head_e.waddr, 2'b00} : ld_addr;
    dm_be   = drain ? head_e.be : 4'h0;
    dm_wd   = head_e.data;
    dm_pc   = head_e.pc;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
    end else if (enq) begin
      entries_q[tail_q] <= '{pc: st_pc, waddr: st_addr[31:2], data: st_wdata, be: st_be};
    end
  end

  // Forwarding sees only registered entries, so a same-cycle enqueue is invisible.
  sb_fwd_merge #(
    .DEPTH(DEPTH)
  ) u_fwd_merge (
    .entries_i  (entries_q),
    .valid_i    (valid),
    .head_i     (head_q),
    .ld_waddr_i (ld_addr[31:2]),
    .dm_rd_i    (dm_rd),
    .ld_data_o  (ld_data)
  );

endmodule
